// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle command sequencer sitting in front of an external combinational
// 8-bit ALU. It owns a small register file, accepts one command at a time,
// fetches operand A from the register file and operand B from the register
// file or an immediate, then runs the ALU 1..8 times with the result fed back
// as operand A. The final result is written back (except for compare) and
// reported on done/done_result together with the last {N,V,Z,C} flags.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the sequencer is idle
// and does not depend on cmd_valid; while busy, cmd_valid is ignored and the
// presented command stays pending on the source side.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   cmd_*            command channel (valid/ready, opcode, register addresses,
//                    immediate select/value, extra iteration count)
//   alu_a/b/op       registered operands and opcode towards the ALU
//   alu_result/...   combinational ALU result and flags
//   done             one-cycle pulse when a command retires
//   done_result      final result (valid with done, held afterwards)
//   flags            {N,V,Z,C} of the last executed iteration
//   host_*           host write port and combinational read port
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic          cmd_imm_sel,
    input  logic [7:0]    cmd_imm,
    input  logic [2:0]    cmd_count,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_op,
    input  logic [7:0]    alu_result,
    input  logic          alu_carry,
    input  logic          alu_zero,
    input  logic          alu_ovf,
    input  logic          alu_neg,
    output logic          done,
    output logic [7:0]    done_result,
    output logic [3:0]    flags,
    input  logic          host_we,
    input  logic [AW-1:0] host_waddr,
    input  logic [7:0]    host_wdata,
    input  logic [AW-1:0] host_raddr,
    output logic [7:0]    host_rdata
);

    localparam logic [3:0] OP_CMP = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rf_q [NREG];
    logic [7:0]      rf_d [NREG];
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      opb_q, opb_d;
    logic [3:0]      op_q, op_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [2:0]      iter_q, iter_d;
    logic [3:0]      flags_q, flags_d;
    logic [7:0]      done_result_q, done_result_d;

    // ALU inputs come straight from flops so they are stable for the whole
    // EXEC cycle; outside EXEC they simply show the last latched values.
    assign alu_a      = acc_q;
    assign alu_b      = opb_q;
    assign alu_op     = op_q;
    assign flags      = flags_q;
    assign host_rdata = rf_q[host_raddr];

    always_comb begin
        state_d       = state_q;
        rf_d          = rf_q;
        acc_d         = acc_q;
        opb_d         = opb_q;
        op_d          = op_q;
        dst_d         = dst_q;
        iter_d        = iter_q;
        flags_d       = flags_q;
        done_result_d = done_result_q;
        cmd_ready     = 1'b0;
        done          = 1'b0;
        done_result   = done_result_q;

        // Host write first so that a writeback to the same address in the
        // same cycle overrides it below.
        if (host_we) begin
            rf_d[host_waddr] = host_wdata;
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Operands come from rf_q, i.e. the contents before any
                    // host write landing on this same edge.
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    iter_d  = cmd_count;
                    acc_d   = rf_q[cmd_src_a];
                    opb_d   = cmd_imm_sel ? cmd_imm : rf_q[cmd_src_b];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_d   = alu_result;
                flags_d = {alu_neg, alu_ovf, alu_zero, alu_carry};
                if (iter_q == 3'd0) begin
                    state_d = S_WB;
                end else begin
                    iter_d = iter_q - 3'd1;
                end
            end
            S_WB: begin
                done          = 1'b1;
                done_result   = acc_q;
                done_result_d = acc_q;
                // Compare only updates flags; the result is reported but not
                // stored.
                if (op_q != OP_CMP) begin
                    rf_d[dst_q] = acc_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            opb_q         <= '0;
            op_q          <= '0;
            dst_q         <= '0;
            iter_q        <= '0;
            flags_q       <= '0;
            done_result_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            opb_q         <= opb_d;
            op_q          <= op_d;
            dst_q         <= dst_d;
            iter_q        <= iter_d;
            flags_q       <= flags_d;
            done_result_q <= done_result_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Drives alu_sequencer with directed and randomized commands plus host
// register traffic. A behavioural ALU answers the DUT's alu_* requests. A
// transaction-level model computes each command's full result at accept time
// and predicts the cycle it retires; a compare process checks the DUT outputs
// against it every cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int NREG = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src_a;
    logic [AW-1:0] cmd_src_b;
    logic          cmd_imm_sel;
    logic [7:0]    cmd_imm;
    logic [2:0]    cmd_count;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_op;
    logic [7:0]    alu_result;
    logic          alu_carry;
    logic          alu_zero;
    logic          alu_ovf;
    logic          alu_neg;
    logic          done;
    logic [7:0]    done_result;
    logic [3:0]    flags;
    logic          host_we;
    logic [AW-1:0] host_waddr;
    logic [7:0]    host_wdata;
    logic [AW-1:0] host_raddr;
    logic [7:0]    host_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done_dut = 0;
    bit rand_host = 1'b0;

    alu_sequencer #(.NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_count(cmd_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_neg(alu_neg),
        .done(done), .done_result(done_result), .flags(flags),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural ALU: returns {N,V,Z,C,result} -----------
    function automatic logic [11:0] alu_fn(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1, 4'hF: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h8: begin
                r = {a[6:0], 1'b0};
                c = a[7];
            end
            4'h9: begin
                r = {1'b0, a[7:1]};
                c = a[0];
            end
            default: r = a ^ ~b;
        endcase
        return {r[7], v, (r == 8'h00), c, r};
    endfunction

    always_comb begin
        {alu_neg, alu_ovf, alu_zero, alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // cyc numbers the cycle that begins at each rising edge. A command
    // accepted on the edge opening cycle S occupies cycles S..S+count as
    // iterations and retires (done) in cycle S+count+1.
    int            cyc = 0;
    bit            m_valid = 1'b0;
    logic [7:0]    m_regs [NREG];
    int            m_start = -1;
    int            m_wb = -1;
    logic [3:0]    m_op;
    logic [AW-1:0] m_dst;
    logic [7:0]    m_a;
    logic [7:0]    m_opb;
    logic [7:0]    m_res;
    logic [3:0]    m_res_flags;
    logic [3:0]    m_flags;
    logic [7:0]    m_done_res;

    always @(posedge clk) begin : model
        int          prev;
        bit          take;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  x;
        logic [11:0] o;
        prev = cyc;
        cyc  = cyc + 1;
        if (rst) begin
            m_valid    = 1'b1;
            for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
            m_flags    = 4'h0;
            m_done_res = 8'h00;
            m_start    = -1;
            m_wb       = -1;
        end else if (m_valid) begin
            take = !(prev >= m_start && prev <= m_wb) && (cmd_valid === 1'b1);
            o = '0;
            a = '0;
            b = '0;
            x = '0;
            if (take) begin
                a = m_regs[cmd_src_a];
                b = cmd_imm_sel ? cmd_imm : m_regs[cmd_src_b];
                x = a;
                for (int i = 0; i <= int'(cmd_count); i++) begin
                    o = alu_fn(cmd_op, x, b);
                    x = o[7:0];
                end
            end
            if (host_we) m_regs[host_waddr] = host_wdata;
            if (prev == m_wb) begin
                if (m_op != 4'hF) m_regs[m_dst] = m_res;
                m_flags    = m_res_flags;
                m_done_res = m_res;
            end
            if (take) begin
                m_op        = cmd_op;
                m_dst       = cmd_dst;
                m_a         = a;
                m_opb       = b;
                m_res       = x;
                m_res_flags = o[11:8];
                m_start     = cyc;
                m_wb        = cyc + int'(cmd_count) + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit in_exec;
        bit in_wb;
        if (m_valid) begin
            in_wb   = (cyc == m_wb);
            in_exec = (cyc >= m_start) && (cyc < m_wb);
            chk("cmd_ready", cmd_ready, !(in_exec || in_wb));
            chk("done", done, in_wb);
            if (in_wb) begin
                chk("done_result", done_result, m_res);
                chk("flags_wb", flags, m_res_flags);
            end else if (!in_exec) begin
                chk("done_result_hold", done_result, m_done_res);
                chk("flags_hold", flags, m_flags);
            end else begin
                chk("alu_op", alu_op, m_op);
                chk("alu_b", alu_b, m_opb);
                if (cyc == m_start) chk("alu_a_first", alu_a, m_a);
            end
            chk("host_rdata", host_rdata, m_regs[host_raddr]);
            if (done === 1'b1) n_done_dut++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_host) begin
            host_we    = ($urandom_range(0, 3) == 0);
            host_waddr = AW'($urandom_range(0, NREG - 1));
            host_wdata = 8'($urandom_range(0, 255));
            host_raddr = AW'($urandom_range(0, NREG - 1));
        end
    endtask

    task automatic host_write(input logic [AW-1:0] addr, input logic [7:0] data);
        host_we    = 1'b1;
        host_waddr = addr;
        host_wdata = data;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic read_reg(input logic [AW-1:0] addr, output logic [7:0] val);
        host_raddr = addr;
        #1;
        val = host_rdata;
    endtask

    // Presents a command and returns once it has been taken; the caller is
    // then in the first iteration cycle.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] dst,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic isel, input logic [7:0] imm,
                         input logic [2:0] cnt, input bit keep_valid);
        bit r;
        bit ok;
        cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_count = cnt;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = cmd_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (!keep_valid) begin
            cmd_valid = 1'b0;
            cmd_op    = 4'($urandom_range(0, 15));
            cmd_dst   = AW'($urandom_range(0, NREG - 1));
            cmd_count = 3'($urandom_range(0, 7));
        end
    endtask

    // Waits for done; lat counts cycles from the first iteration cycle
    // (1) up to and including the done cycle. Returns in the cycle after.
    task automatic wait_done(output int lat, output logic [7:0] res, output logic [3:0] fl);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        res  = '0;
        fl   = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                res  = done_result;
                fl   = flags;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          lat;
        logic [7:0]  res;
        logic [3:0]  fl;
        logic [7:0]  v;
        logic [7:0]  v2;
        int          prev_acc;
        int          prev_cnt;
        int          base;
        int          n_rand;
        logic [2:0]  cnt;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
        cmd_imm_sel = 1'b0; cmd_imm = '0; cmd_count = '0;
        host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_done_result", done_result, 8'h00);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alu_op", alu_op, 4'h0);
        for (int i = 0; i < NREG; i++) begin
            read_reg(AW'(i), v);
            chk("rst_reg", v, 8'h00);
        end

        // ADD 0x7F + 0x01 -> 0x80, {N,V,Z,C} = 1100
        host_write(2'd1, 8'h7F);
        host_write(2'd2, 8'h01);
        issue(4'h0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 3'd0, 1'b0);
        wait_done(lat, res, fl);
        chk("add_latency", lat, 2);
        chk("add_result", res, 8'h80);
        chk("add_flags", fl, 4'b1100);
        read_reg(2'd0, v);
        chk("add_r0", v, 8'h80);

        // LSL 0x11 four times -> 0x10, last step 0x88 shifts out carry
        host_write(2'd3, 8'h11);
        issue(4'h8, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 3'd3, 1'b0);
        wait_done(lat, res, fl);
        chk("lsl_latency", lat, 5);
        chk("lsl_result", res, 8'h10);
        chk("lsl_flags", fl, 4'b0001);
        read_reg(2'd3, v);
        chk("lsl_r3", v, 8'h10);

        // SUB 0x00 - imm 0x01 -> 0xFF with borrow
        host_write(2'd1, 8'h00);
        issue(4'h1, 2'd2, 2'd1, 2'd3, 1'b1, 8'h01, 3'd0, 1'b0);
        wait_done(lat, res, fl);
        chk("sub_result", res, 8'hFF);
        chk("sub_flags", fl, 4'b1001);
        read_reg(2'd2, v);
        chk("sub_r2", v, 8'hFF);

        // Compare r0 with itself: zero result, no register write
        issue(4'hF, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        wait_done(lat, res, fl);
        chk("cmp_result", res, 8'h00);
        chk("cmp_flags", fl, 4'b0010);
        read_reg(2'd0, v);
        chk("cmp_r0_kept", v, 8'h80);

        // cmd_valid held high across back-to-back commands
        base = n_done_dut;
        prev_acc = -1;
        prev_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cnt = 3'($urandom_range(0, 3));
            issue(4'($urandom_range(0, 4)), AW'($urandom_range(0, NREG - 1)),
                  AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), cnt, 1'b1);
            if (prev_acc >= 0) chk("b2b_gap", cyc - prev_acc, prev_cnt + 3);
            prev_acc = cyc;
            prev_cnt = int'(cnt);
        end
        cmd_valid = 1'b0;
        repeat (8) tick();
        chk("b2b_done_count", n_done_dut - base, 6);

        // Host write to the writeback address in the WB cycle: WB wins
        host_write(2'd1, 8'h10);
        host_write(2'd2, 8'h05);
        issue(4'h0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        host_we = 1'b1; host_waddr = 2'd0; host_wdata = 8'h55;
        tick();
        host_we = 1'b0;
        read_reg(2'd0, v);
        chk("wb_wins_r0", v, 8'h15);

        // Host write to another address in the WB cycle: both land
        issue(4'h0, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        host_we = 1'b1; host_waddr = 2'd3; host_wdata = 8'h66;
        tick();
        host_we = 1'b0;
        read_reg(2'd0, v);
        read_reg(2'd3, v2);
        chk("both_r0", v, 8'h20);
        chk("both_r3", v2, 8'h66);

        // Reset during the third iteration of an eight-iteration command
        host_write(2'd1, 8'h03);
        issue(4'h8, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 3'd7, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = n_done_dut;
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_flags", flags, 4'h0);
        chk("abort_done_result", done_result, 8'h00);
        for (int i = 0; i < NREG; i++) begin
            read_reg(AW'(i), v);
            chk("abort_reg", v, 8'h00);
        end
        repeat (10) tick();
        chk("abort_no_done", n_done_dut - base, 0);

        // Randomized commands with concurrent host traffic
        rand_host = 1'b1;
        base = n_done_dut;
        n_rand = 150;
        for (int k = 0; k < n_rand; k++) begin
            issue(4'($urandom_range(0, 15)), AW'($urandom_range(0, NREG - 1)),
                  AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                cmd_valid = 1'b0;
                tick();
            end
        end
        cmd_valid = 1'b0;
        repeat (12) tick();
        chk("rand_done_count", n_done_dut - base, n_rand);
        rand_host = 1'b0;
        host_we = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
